// File: rtl/lowx_arbiter_if.sv
// rtl/lowx_arbiter_if.sv - cache-pair and lower-level memory port bundle for lowx_arbiter
interface lowx_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
);
    logic                ic_req_valid_i;
    logic [XLEN-1:0]     ic_req_addr_i;
    logic                ic_req_uncached_i;
    logic                ic_res_valid_o;
    logic [BLK_SIZE-1:0] ic_res_data_o;

    logic                dc_req_valid_i;
    logic [XLEN-1:0]     dc_req_addr_i;
    logic                dc_req_rw_i;
    logic [1:0]          dc_req_rw_size_i;
    logic                dc_req_uncached_i;
    logic [BLK_SIZE-1:0] dc_req_data_i;
    logic                dc_res_valid_o;
    logic [BLK_SIZE-1:0] dc_res_data_o;

    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [XLEN-1:0]     mem_req_addr_o;
    logic                mem_req_rw_o;
    logic [1:0]          mem_req_rw_size_o;
    logic                mem_req_uncached_o;
    logic [BLK_SIZE-1:0] mem_req_data_o;
    logic                mem_res_valid_i;
    logic [BLK_SIZE-1:0] mem_res_data_i;
    logic                mem_res_ready_o;

    modport master (
        input  ic_req_valid_i, ic_req_addr_i, ic_req_uncached_i,
        output ic_res_valid_o, ic_res_data_o,
        input  dc_req_valid_i, dc_req_addr_i, dc_req_rw_i, dc_req_rw_size_i,
        input  dc_req_uncached_i, dc_req_data_i,
        output dc_res_valid_o, dc_res_data_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_rw_size_o,
        output mem_req_uncached_o, mem_req_data_o, mem_res_ready_o,
        input  mem_req_ready_i, mem_res_valid_i, mem_res_data_i
    );

    modport slave (
        output ic_req_valid_i, ic_req_addr_i, ic_req_uncached_i,
        input  ic_res_valid_o, ic_res_data_o,
        output dc_req_valid_i, dc_req_addr_i, dc_req_rw_i, dc_req_rw_size_i,
        output dc_req_uncached_i, dc_req_data_i,
        input  dc_res_valid_o, dc_res_data_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_rw_size_o,
        input  mem_req_uncached_o, mem_req_data_o, mem_res_ready_o,
        output mem_req_ready_i, mem_res_valid_i, mem_res_data_i
    );
endinterface

// File: rtl/lowx_arbiter.sv
// rtl/lowx_arbiter.sv - round-robin icache/dcache arbiter for a single outstanding lowX memory transaction
module lowx_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    lowx_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q;
    logic                last_grant_q;
    logic [1:0]          holdoff_q;
    logic [XLEN-1:0]     addr_q;
    logic                rw_q;
    logic [1:0]          size_q;
    logic                unc_q;
    logic [BLK_SIZE-1:0] data_q;
    logic [BLK_SIZE-1:0] res_q;

    logic ic_elig, dc_elig, grant_ic, grant_dc;

    // holdoff_q[0] masks the icache, holdoff_q[1] the dcache, for the one IDLE cycle after its response
    assign ic_elig  = bus.ic_req_valid_i & ~holdoff_q[0];
    assign dc_elig  = bus.dc_req_valid_i & ~holdoff_q[1];
    assign grant_dc = (state_q == S_IDLE) & dc_elig & (~ic_elig | (last_grant_q == OWN_IC));
    assign grant_ic = (state_q == S_IDLE) & ic_elig & ~grant_dc;

    always_comb begin
        state_d                = state_q;
        bus.mem_req_valid_o    = 1'b0;
        bus.mem_req_addr_o     = '0;
        bus.mem_req_rw_o       = 1'b0;
        bus.mem_req_rw_size_o  = 2'b00;
        bus.mem_req_uncached_o = 1'b0;
        bus.mem_req_data_o     = '0;
        bus.mem_res_ready_o    = 1'b0;
        bus.ic_res_valid_o     = 1'b0;
        bus.ic_res_data_o      = '0;
        bus.dc_res_valid_o     = 1'b0;
        bus.dc_res_data_o      = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_ic | grant_dc) state_d = S_REQ;
            end
            S_REQ: begin
                bus.mem_req_valid_o    = 1'b1;
                bus.mem_req_addr_o     = addr_q;
                bus.mem_req_rw_o       = rw_q;
                bus.mem_req_rw_size_o  = size_q;
                bus.mem_req_uncached_o = unc_q;
                bus.mem_req_data_o     = data_q;
                if (bus.mem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                bus.mem_res_ready_o = 1'b1;
                if (bus.mem_res_valid_i) state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q == OWN_DC) begin
                    bus.dc_res_valid_o = 1'b1;
                    bus.dc_res_data_o  = res_q;
                end else begin
                    bus.ic_res_valid_o = 1'b1;
                    bus.ic_res_data_o  = res_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IC;
            last_grant_q <= OWN_IC;
            holdoff_q    <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            size_q       <= 2'b00;
            unc_q        <= 1'b0;
            data_q       <= '0;
            res_q        <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    holdoff_q <= '0;
                    if (grant_dc) begin
                        owner_q      <= OWN_DC;
                        last_grant_q <= OWN_DC;
                        addr_q       <= bus.dc_req_addr_i;
                        rw_q         <= bus.dc_req_rw_i;
                        size_q       <= bus.dc_req_rw_size_i;
                        unc_q        <= bus.dc_req_uncached_i;
                        data_q       <= bus.dc_req_data_i;
                    end else if (grant_ic) begin
                        // instruction fetches are always full-line reads
                        owner_q      <= OWN_IC;
                        last_grant_q <= OWN_IC;
                        addr_q       <= bus.ic_req_addr_i;
                        rw_q         <= 1'b0;
                        size_q       <= 2'b11;
                        unc_q        <= bus.ic_req_uncached_i;
                        data_q       <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_res_valid_i) res_q <= bus.mem_res_data_i;
                end
                S_RESP: begin
                    holdoff_q[owner_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lowx_arbiter.sv
// tb/tb_lowx_arbiter.sv - directed bench with a per-cycle reference model for lowx_arbiter
module tb_lowx_arbiter;
    localparam int XLEN = 32;
    localparam int BLK  = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lowx_arbiter_if #(.XLEN(XLEN), .BLK_SIZE(BLK)) bus ();

    lowx_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: transaction flags, not a state encoding
    bit              chk_en = 1'b0;
    bit              m_busy, m_acc, m_pulse, m_own, m_last, m_hold_ic, m_hold_dc;
    logic [XLEN-1:0] m_addr;
    logic            m_rw, m_unc;
    logic [1:0]      m_size;
    logic [BLK-1:0]  m_data, m_res;

    // Observation logs
    logic [XLEN-1:0] acc_addr[$];
    logic            acc_rw[$];
    logic [1:0]      acc_size[$];
    int              ic_pulses, dc_pulses, req_valid_cycles, stray_seen;
    logic [BLK-1:0]  ic_last, dc_last;

    initial begin
        m_busy = 0; m_acc = 0; m_pulse = 0; m_own = 0; m_last = 0; m_hold_ic = 0; m_hold_dc = 0;
        m_addr = '0; m_rw = 0; m_unc = 0; m_size = '0; m_data = '0; m_res = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mem_req_valid", bus.mem_req_valid_o, m_busy && !m_acc);
                check("mem_res_ready", bus.mem_res_ready_o, m_busy && m_acc);
                check("ic_res_valid", bus.ic_res_valid_o, m_pulse && !m_own);
                check("dc_res_valid", bus.dc_res_valid_o, m_pulse && m_own);
                check("ic_res_data", bus.ic_res_data_o, (m_pulse && !m_own) ? m_res : '0);
                check("dc_res_data", bus.dc_res_data_o, (m_pulse && m_own) ? m_res : '0);
                if (m_busy && !m_acc) begin
                    check("mem_req_addr", bus.mem_req_addr_o, m_addr);
                    check("mem_req_rw", bus.mem_req_rw_o, m_rw);
                    check("mem_req_size", bus.mem_req_rw_size_o, m_size);
                    check("mem_req_unc", bus.mem_req_uncached_o, m_unc);
                    check("mem_req_data", bus.mem_req_data_o, m_data);
                end
                if (bus.mem_req_valid_o) req_valid_cycles++;
                if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
                    acc_addr.push_back(bus.mem_req_addr_o);
                    acc_rw.push_back(bus.mem_req_rw_o);
                    acc_size.push_back(bus.mem_req_rw_size_o);
                end
                if (bus.mem_res_valid_i && !bus.mem_res_ready_o) stray_seen++;
                if (bus.ic_res_valid_o) begin ic_pulses++; ic_last = bus.ic_res_data_o; end
                if (bus.dc_res_valid_o) begin dc_pulses++; dc_last = bus.dc_res_data_o; end
            end
            // advance to the next cycle from the inputs about to be sampled
            if (!rst_n) begin
                m_busy = 0; m_acc = 0; m_pulse = 0; m_own = 0; m_last = 0;
                m_hold_ic = 0; m_hold_dc = 0; m_res = '0;
            end else if (m_pulse) begin
                m_pulse   = 0;
                m_hold_ic = !m_own;
                m_hold_dc = m_own;
            end else if (m_busy && !m_acc) begin
                if (bus.mem_req_ready_i) m_acc = 1;
            end else if (m_busy) begin
                if (bus.mem_res_valid_i) begin
                    m_busy = 0; m_pulse = 1; m_res = bus.mem_res_data_i;
                end
            end else begin
                bit e_ic, e_dc;
                e_ic = bus.ic_req_valid_i && !m_hold_ic;
                e_dc = bus.dc_req_valid_i && !m_hold_dc;
                m_hold_ic = 0; m_hold_dc = 0;
                if (e_dc && (!e_ic || m_last == 0)) begin
                    m_busy = 1; m_acc = 0; m_own = 1; m_last = 1;
                    m_addr = bus.dc_req_addr_i; m_rw = bus.dc_req_rw_i; m_size = bus.dc_req_rw_size_i;
                    m_unc = bus.dc_req_uncached_i; m_data = bus.dc_req_data_i;
                end else if (e_ic) begin
                    m_busy = 1; m_acc = 0; m_own = 0; m_last = 0;
                    m_addr = bus.ic_req_addr_i; m_rw = 0; m_size = 2'b11;
                    m_unc = bus.ic_req_uncached_i; m_data = '0;
                end
            end
        end
    end

    // Memory responder: optional stall, fixed response latency, optional stray pulse during REQ
    int              stall = 0;
    int              res_lat = 0;
    int              cnt = 0;
    bit              spray = 0;
    logic [XLEN-1:0] pend_addr = '0;
    logic [BLK-1:0]  resp_base = {4{32'hA5A5_A5A5}};
    initial begin
        bus.mem_req_ready_i = 0; bus.mem_res_valid_i = 0; bus.mem_res_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_res_valid_i = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem_res_valid_i = 1;
                    bus.mem_res_data_i  = resp_base ^ {4{pend_addr}};
                end
            end
            if (bus.mem_req_valid_o) begin
                if (stall > 0) begin
                    stall--;
                    bus.mem_req_ready_i = 0;
                end else begin
                    bus.mem_req_ready_i = 1;
                    cnt = res_lat + 1;
                    pend_addr = bus.mem_req_addr_o;
                    if (spray) begin
                        bus.mem_res_valid_i = 1;
                        bus.mem_res_data_i  = {4{32'h0BAD_0BAD}};
                    end
                end
            end else begin
                bus.mem_req_ready_i = 0;
            end
        end
    end

    task automatic clear_logs();
        acc_addr.delete(); acc_rw.delete(); acc_size.delete();
        ic_pulses = 0; dc_pulses = 0; req_valid_cycles = 0; stray_seen = 0;
        ic_last = '0; dc_last = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.ic_req_valid_i = 0; bus.ic_req_addr_i = '0; bus.ic_req_uncached_i = 0;
        bus.dc_req_valid_i = 0; bus.dc_req_addr_i = '0; bus.dc_req_rw_i = 0;
        bus.dc_req_rw_size_i = 2'b00; bus.dc_req_uncached_i = 0; bus.dc_req_data_i = '0;
        stall = 0; res_lat = 0; spray = 0; cnt = 0;
        cyc(2);
        rst_n = 1;
        chk_en = 1;
        clear_logs();
    endtask

    task automatic wait_ic();
        int k = 0;
        while (!bus.ic_res_valid_o && k < 200) begin cyc(1); k++; end
        if (!bus.ic_res_valid_o) begin
            n_cmp++; n_bad++;
            $display("FAIL ic_timeout: actual no response required response within 200 cycles");
        end
    endtask

    task automatic wait_dc();
        int k = 0;
        while (!bus.dc_res_valid_o && k < 200) begin cyc(1); k++; end
        if (!bus.dc_res_valid_o) begin
            n_cmp++; n_bad++;
            $display("FAIL dc_timeout: actual no response required response within 200 cycles");
        end
    endtask

    // Caches hold the request through the cycle after the response, then drop or change it
    task automatic ic_txn(input logic [XLEN-1:0] a);
        bus.ic_req_valid_i = 1; bus.ic_req_addr_i = a; bus.ic_req_uncached_i = 0;
        wait_ic();
        cyc(2);
        bus.ic_req_valid_i = 0;
    endtask

    task automatic dc_txn(input logic [XLEN-1:0] a, input logic rw, input logic [1:0] sz,
                          input logic unc, input logic [BLK-1:0] d, input bit drop);
        bus.dc_req_valid_i = 1; bus.dc_req_addr_i = a; bus.dc_req_rw_i = rw;
        bus.dc_req_rw_size_i = sz; bus.dc_req_uncached_i = unc; bus.dc_req_data_i = d;
        wait_dc();
        cyc(2);
        if (drop) bus.dc_req_valid_i = 0;
    endtask

    task automatic check_order(input string name, input logic [XLEN-1:0] exp[$]);
        check({name, "_count"}, acc_addr.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_addr.size(); i++)
            check($sformatf("%s_%0d", name, i), acc_addr[i], exp[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] ord[$];
        do_reset();

        // 1: icache fetch, stray same-cycle pulse at acceptance, response 3 cycles later
        check("reset_req_valid", bus.mem_req_valid_o, 1'b0);
        check("reset_res_ready", bus.mem_res_ready_o, 1'b0);
        check("reset_ic_valid", bus.ic_res_valid_o, 1'b0);
        spray = 1; res_lat = 2;
        ic_txn(32'h0000_1000);
        cyc(3);
        check("t1_ic_pulses", ic_pulses, 1);
        check("t1_ic_data", ic_last, 128'hA5A5B5A5_A5A5B5A5_A5A5B5A5_A5A5B5A5);
        check("t1_dc_pulses", dc_pulses, 0);
        ord = '{32'h0000_1000};
        check_order("t1_order", ord);
        if (acc_rw.size() > 0) begin
            check("t1_rw", acc_rw[0], 1'b0);
            check("t1_size", acc_size[0], 2'b11);
        end

        // 2: simultaneous contests after reset go DC, IC, then DC again
        do_reset();
        fork
            ic_txn(32'h0000_3000);
            dc_txn(32'h0000_2000, 1'b0, 2'b11, 1'b0, '0, 1'b1);
        join
        fork
            ic_txn(32'h0000_3040);
            dc_txn(32'h0000_2040, 1'b0, 2'b00, 1'b1, '0, 1'b1);
        join
        ord = '{32'h0000_2000, 32'h0000_3000, 32'h0000_2040, 32'h0000_3040};
        check_order("t2_order", ord);

        // 2b: after a lone DC grant the next contest goes to IC
        do_reset();
        dc_txn(32'h0000_2100, 1'b0, 2'b11, 1'b0, '0, 1'b1);
        fork
            ic_txn(32'h0000_3100);
            dc_txn(32'h0000_2200, 1'b0, 2'b11, 1'b0, '0, 1'b1);
        join
        ord = '{32'h0000_2100, 32'h0000_3100, 32'h0000_2200};
        check_order("t2b_order", ord);

        // 3: write-back, waiting icache wins, then the held fill
        do_reset();
        res_lat = 1;
        fork
            begin
                dc_txn(32'h0000_4000, 1'b1, 2'b11, 1'b0, {4{32'hDEAD_BEEF}}, 1'b0);
                dc_txn(32'h0000_4000, 1'b0, 2'b11, 1'b0, '0, 1'b1);
            end
            begin
                cyc(1);
                ic_txn(32'h0000_5000);
            end
        join
        cyc(4);
        ord = '{32'h0000_4000, 32'h0000_5000, 32'h0000_4000};
        check_order("t3_order", ord);
        if (acc_rw.size() == 3) begin
            check("t3_wb_rw", acc_rw[0], 1'b1);
            check("t3_ic_rw", acc_rw[1], 1'b0);
            check("t3_fill_rw", acc_rw[2], 1'b0);
        end

        // 4: memory stalls for 5 cycles with the request held stable
        do_reset();
        stall = 5;
        dc_txn(32'h0000_6004, 1'b1, 2'b01, 1'b1, 128'h1234, 1'b1);
        check("t4_valid_cycles", req_valid_cycles, 6);
        check("t4_dc_pulses", dc_pulses, 1);

        // 5: requester lingers one cycle after its response with no competitor
        do_reset();
        ic_txn(32'h0000_7000);
        cyc(5);
        check("t5_req_count", acc_addr.size(), 1);
        check("t5_ic_pulses", ic_pulses, 1);

        // 6: reset during WAIT, stray response afterwards, then a clean transaction
        do_reset();
        res_lat = 4;
        bus.ic_req_valid_i = 1; bus.ic_req_addr_i = 32'h0000_8000;
        begin
            int k = 0;
            while (!bus.mem_res_ready_o && k < 50) begin cyc(1); k++; end
            check("t6_reached_wait", bus.mem_res_ready_o, 1'b1);
        end
        rst_n = 0;
        bus.ic_req_valid_i = 0;
        cyc(1);
        rst_n = 1;
        cyc(8);
        check("t6_stray_seen", stray_seen, 1);
        check("t6_no_pulse", ic_pulses, 0);
        check("t6_idle_req", bus.mem_req_valid_o, 1'b0);
        res_lat = 1;
        ic_txn(32'h0000_8800);
        check("t6_new_pulses", ic_pulses, 1);
        check("t6_new_data", ic_last, {4{32'hA5A5_A5A5 ^ 32'h0000_8800}});

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
